fir_stream_ctrl: RTL and testbench

- Sequencing controller that sits between the sigma-delta decimator front-end and the 8-tap fir_filter.
- Converts an upstream valid/ready sample stream into fir_filter valid_in strobes.
- Discards the start-up outputs that contain stale taps, then applies a programmable output decimation.
- Buffers results in a small output FIFO toward a valid/ready consumer. Back-pressure is credit-based, so filter outputs are never lost.

---
 rtl/fir_stream_ctrl.sv | 154 +++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_ctrl.sv
// Stream sequencer between the decimator front-end and the 8-tap fir_filter:
// strobes samples in, drops stale start-up outputs, decimates, and queues results.
module fir_stream_ctrl #(
  parameter int unsigned DW         = 16,
  parameter int unsigned TAPS       = 8,
  parameter int unsigned DECIM_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [DECIM_W-1:0] decim_ratio,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  output logic               fir_valid_in,
  output logic [DW-1:0]      fir_din,
  input  logic               fir_valid_out,
  input  logic [DW-1:0]      fir_dout,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DW-1:0]      m_data,
  output logic               busy,
  output logic               overflow
);

  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW       = $clog2(TAPS + 1);
  localparam int unsigned ROOM_MAX = FIFO_DEPTH - 2;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t             state, state_d;
  logic [CW-1:0]      fifo_count;
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [DW-1:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]      prime_cnt;
  logic [DECIM_W-1:0] phase, ratio_q, phase_inc;
  logic               inflight_q, drain_first, drain_from_run;
  logic               fill_rules, run_rules, room;
  logic               fwd, full, push_ok, pop, prime_last;
  logic [CW-1:0]      count_d, left_after_pop;
  logic [AW-1:0]      rd_nxt;

  assign room       = fifo_count <= CW'(ROOM_MAX);
  assign prime_last = prime_cnt == PW'(TAPS - 1);
  assign phase_inc  = phase + DECIM_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic; DRAIN ignores enable until the pipeline and FIFO are empty
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (enable) state_d = FILL;
      FILL: begin
        if (!enable)                          state_d = DRAIN;
        else if (fir_valid_out && prime_last) state_d = RUN;
      end
      RUN:   if (!enable) state_d = DRAIN;
      DRAIN: if (!inflight_q && fifo_count == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: acceptance and which rule set applies to an arriving result
  always_comb begin
    s_ready    = 1'b0;
    fill_rules = 1'b0;
    run_rules  = 1'b0;
    case (state)
      FILL: begin
        s_ready    = enable & room;
        fill_rules = 1'b1;
      end
      RUN: begin
        s_ready   = enable & room;
        run_rules = 1'b1;
      end
      DRAIN:   run_rules = drain_first & drain_from_run;
      default: ;
    endcase
  end

  assign fir_valid_in = s_valid & s_ready;
  assign fir_din      = s_data;

  // Run control: ratio latch, priming count, decimation phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q     <= 1'b0;
      busy           <= 1'b0;
      drain_first    <= 1'b0;
      drain_from_run <= 1'b0;
      ratio_q        <= DECIM_W'(1);
      prime_cnt      <= '0;
      phase          <= '0;
    end else begin
      inflight_q  <= fir_valid_in;
      busy        <= state_d != IDLE;
      drain_first <= (state != DRAIN) && (state_d == DRAIN);
      if (state != DRAIN && state_d == DRAIN) drain_from_run <= state == RUN;
      if (state == IDLE) begin
        if (state_d == FILL) begin
          ratio_q   <= (decim_ratio == '0) ? DECIM_W'(1) : decim_ratio;
          prime_cnt <= '0;
          phase     <= '0;
        end
      end else begin
        if (fir_valid_out && fill_rules) prime_cnt <= prime_cnt + PW'(1);
        if (fir_valid_out && run_rules)  phase <= (phase_inc == ratio_q) ? '0 : phase_inc;
      end
    end
  end

  assign fwd            = fir_valid_out & run_rules & (phase == '0);
  assign full           = fifo_count == CW'(FIFO_DEPTH);
  assign push_ok        = fwd & ~full;
  assign pop            = m_valid & m_ready;
  assign count_d        = fifo_count + CW'(push_ok) - CW'(pop);
  assign left_after_pop = fifo_count - CW'(pop);
  assign rd_nxt         = rd_ptr + AW'(pop);

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= fir_dout;
  end

  // FIFO control; m_data tracks the head so the first word falls through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      overflow   <= 1'b0;
    end else begin
      fifo_count <= count_d;
      rd_ptr     <= rd_nxt;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      m_valid  <= count_d != '0;
      overflow <= overflow | (fwd & full);
      if (left_after_pop != '0) m_data <= mem[rd_nxt];
      else if (push_ok)         m_data <= fir_dout;
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl with a delay-and-scale fir_filter stand-in
// (dout = previous sample * 20 >>> 15, one cycle after valid_in).
module tb_fir_stream_ctrl;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    decim_ratio = 8'd1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          fir_valid_in;
  logic [DW-1:0] fir_din;
  logic          fir_valid_out = 1'b0;
  logic [DW-1:0] fir_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          busy;
  logic          overflow;

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  logic [DW-1:0] sr0 = '0;
  logic          mv_prev = 1'b0;
  logic [DW-1:0] outq[$];
  int            mv_rise[$];
  int            acc_cyc[$];

  fir_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .decim_ratio(decim_ratio),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fir_valid_in(fir_valid_in), .fir_din(fir_din),
    .fir_valid_out(fir_valid_out), .fir_dout(fir_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Filter stand-in: output k is built from sample k-1, never cleared by reset
  always @(posedge clk) begin
    fir_valid_out <= fir_valid_in;
    if (fir_valid_in) begin
      fir_dout <= DW'((32'(signed'(sr0)) * 20) >>> 15);
      sr0      <= fir_din;
    end
  end

  // Output collector and m_valid rise times
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_valid && m_ready) outq.push_back(m_data);
    if (m_valid && !mv_prev) mv_rise.push_back(cyc);
    mv_prev <= m_valid;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: constant 16384, mode 1: ramp value n*1639 (filter output n)
  task automatic send(input int first, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      int   waits;
      logic done;
      waits = 0;
      done  = 1'b0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = (mode == 0) ? 16'd16384 : DW'((first + i) * 1639);
      while (!done) begin
        #1;
        if (s_ready) begin
          acc_cyc.push_back(cyc);
          done = 1'b1;
        end
        @(posedge clk);
        if (!done) begin
          waits++;
          if (waits > 50) begin
            chk("send_timeout", int'(s_ready), 1);
            done = 1'b1;
          end else begin
            @(negedge clk);
          end
        end
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(busy), 0);
  endtask

  task automatic check_out(input string tag, input int n, input int base, input int step);
    chk($sformatf("%s_count", tag), outq.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_word%0d", tag, i), (i < outq.size()) ? int'(outq[i]) : -1, base + i * step);
  endtask

  task automatic clear_logs();
    outq.delete();
    mv_rise.delete();
    acc_cyc.delete();
  endtask

  initial begin
    int acc;
    int stall;
    int guard;
    int n;

    // Reset state, with an offered sample that must not be accepted
    repeat (3) @(negedge clk);
    s_valid = 1'b1;
    #1;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_fir_valid_in", int'(fir_valid_in), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Constant input, ratio 1: outputs 9..12 forwarded, first m_valid 2 cycles after accept 9
    clear_logs();
    decim_ratio = 8'd1;
    m_ready = 1'b1;
    enable = 1'b1;
    send(1, 12, 0);
    repeat (4) @(negedge clk);
    check_out("dec1", 4, 10, 0);
    chk("dec1_latency", (mv_rise.size() > 0) ? mv_rise[0] : -1,
        (acc_cyc.size() > 8) ? acc_cyc[8] + 2 : -2);
    enable = 1'b0;
    wait_idle("dec1_idle");

    // Ratio 3 on a ramp; ratio change after start must not take effect
    clear_logs();
    decim_ratio = 8'd3;
    enable = 1'b1;
    send(1, 2, 1);
    decim_ratio = 8'd1;
    send(3, 18, 1);
    repeat (4) @(negedge clk);
    check_out("dec3", 4, 8, 3);
    enable = 1'b0;
    wait_idle("dec3_idle");

    // Ratio 0 behaves as 1
    clear_logs();
    decim_ratio = 8'd0;
    enable = 1'b1;
    send(1, 12, 0);
    repeat (4) @(negedge clk);
    check_out("dec0", 4, 10, 0);
    enable = 1'b0;
    wait_idle("dec0_idle");

    // Back-pressure: 4 words fit before s_ready falls, then drain in order
    clear_logs();
    decim_ratio = 8'd1;
    m_ready = 1'b0;
    enable = 1'b1;
    send(1, 8, 1);
    n = 9;
    acc = 0;
    stall = 0;
    guard = 0;
    while (stall < 4 && guard < 40) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = DW'(n * 1639);
      #1;
      if (s_ready) begin
        acc++;
        n++;
        stall = 0;
      end else begin
        stall++;
      end
      guard++;
    end
    chk("bp_accepts", acc, 4);
    chk("bp_s_ready", int'(s_ready), 0);
    chk("bp_m_valid", int'(m_valid), 1);
    chk("bp_m_data_head", int'(m_data), 8);
    chk("bp_overflow_full", int'(overflow), 0);
    m_ready = 1'b1;
    send(n, 4, 1);
    repeat (4) @(negedge clk);
    check_out("bp", 8, 8, 1);
    chk("bp_overflow", int'(overflow), 0);
    enable = 1'b0;
    wait_idle("bp_idle");

    // Disable mid-RUN with two words queued
    clear_logs();
    m_ready = 1'b0;
    enable = 1'b1;
    send(1, 10, 1);
    repeat (3) @(negedge clk);
    enable  = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = DW'(11 * 1639);
    #1;
    chk("drain_s_ready", int'(s_ready), 0);
    chk("drain_fir_valid_in", int'(fir_valid_in), 0);
    @(negedge clk);
    chk("drain_busy", int'(busy), 1);
    s_valid = 1'b0;
    wait_idle("drain_idle");
    chk("drain_m_valid", int'(m_valid), 0);
    check_out("drain", 2, 8, 1);

    // Re-enable repeats the priming phase
    clear_logs();
    enable = 1'b1;
    send(1, 12, 0);
    repeat (4) @(negedge clk);
    check_out("refill", 4, 10, 0);
    enable = 1'b0;
    wait_idle("refill_idle");

    // Async reset in the middle of FILL
    clear_logs();
    m_ready = 1'b1;
    enable = 1'b1;
    send(1, 5, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", int'(m_valid), 0);
    chk("arst_s_ready", int'(s_ready), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    send(1, 12, 1);
    repeat (4) @(negedge clk);
    check_out("arst", 4, 8, 1);
    enable = 1'b0;
    wait_idle("arst_idle");
    chk("end_overflow", int'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
